// File: rtl/sfp_pkg.sv
// Shared types and constants for the sfp sequencer: FSM states, default widths, SRAM pipeline depth.
// SRAM strobes are active-low; the *_ON constants are the asserted levels.
package sfp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } sfp_state_e;

  localparam int ADDR_BW_DEF = 11;
  localparam int CNT_BW_DEF  = 11;
  localparam int SRAM_LAT    = 1;

  localparam logic CEN_ON  = 1'b0;
  localparam logic CEN_OFF = 1'b1;
  localparam logic WEN_ON  = 1'b0;
  localparam logic WEN_OFF = 1'b1;

endpackage

// File: rtl/sfp_ctrl_if.sv
// Control/status and SRAM strobe bundle of the sfp sequencer.
// master = sequencer side, slave = corelet / SRAM / sfp side.
interface sfp_ctrl_if
  import sfp_pkg::*;
#(
  parameter int addr_bw = ADDR_BW_DEF,
  parameter int cnt_bw  = CNT_BW_DEF
) ();

  logic               start;
  logic [cnt_bw-1:0]  cfg_tiles;
  logic [cnt_bw-1:0]  cfg_rows;
  logic               busy;
  logic               done;
  logic               psum_cen;
  logic               psum_wen;
  logic [addr_bw-1:0] psum_a;
  logic               sfp_acc_en;
  logic               sfp_write_en;
  logic               out_cen;
  logic               out_wen;
  logic [addr_bw-1:0] out_a;

  modport master (
    input  start, cfg_tiles, cfg_rows,
    output busy, done, psum_cen, psum_wen, psum_a,
           sfp_acc_en, sfp_write_en, out_cen, out_wen, out_a
  );

  modport slave (
    output start, cfg_tiles, cfg_rows,
    input  busy, done, psum_cen, psum_wen, psum_a,
           sfp_acc_en, sfp_write_en, out_cen, out_wen, out_a
  );

endinterface

// File: rtl/sfp_addr_gen.sv
// Psum address walker, row-outer / tile-inner; address is a running base (+rows per tile), no multiplier.
// Outputs describe the read about to issue; i_load restarts at (row 0, tile 0) in the same cycle.
module sfp_addr_gen
  import sfp_pkg::*;
#(
  parameter int addr_bw = ADDR_BW_DEF,
  parameter int cnt_bw  = CNT_BW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [cnt_bw-1:0]  i_tiles,
  input  logic [cnt_bw-1:0]  i_rows,
  output logic [addr_bw-1:0] o_addr,
  output logic [addr_bw-1:0] o_row,
  output logic               o_last_tile,
  output logic               o_last_read
);

  logic [cnt_bw-1:0]  r_tiles;
  logic [cnt_bw-1:0]  r_rows;
  logic [cnt_bw-1:0]  r_t;
  logic [cnt_bw-1:0]  r_r;
  logic [addr_bw-1:0] r_base;

  logic [cnt_bw-1:0]  w_tiles;
  logic [cnt_bw-1:0]  w_rows;
  logic [cnt_bw-1:0]  w_t;
  logic [cnt_bw-1:0]  w_r;
  logic [addr_bw-1:0] w_base;

  always_comb begin
    w_tiles = r_tiles;
    w_rows  = r_rows;
    w_t     = r_t;
    w_r     = r_r;
    w_base  = r_base;
    if (i_load) begin
      w_tiles = i_tiles;
      w_rows  = i_rows;
      w_t     = '0;
      w_r     = '0;
      w_base  = '0;
    end
  end

  assign o_addr      = w_base;
  assign o_row       = addr_bw'(w_r);
  assign o_last_tile = (w_t == w_tiles - cnt_bw'(1));
  assign o_last_read = o_last_tile && (w_r == w_rows - cnt_bw'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tiles <= '0;
      r_rows  <= '0;
      r_t     <= '0;
      r_r     <= '0;
      r_base  <= '0;
    end else begin
      if (i_load) begin
        r_tiles <= i_tiles;
        r_rows  <= i_rows;
      end
      if (i_step) begin
        // Row change: base of the next row is simply its row index (tile 0).
        if (o_last_tile) begin
          r_t    <= '0;
          r_r    <= w_r + cnt_bw'(1);
          r_base <= addr_bw'(w_r + cnt_bw'(1));
        end else begin
          r_t    <= w_t + cnt_bw'(1);
          r_r    <= w_r;
          r_base <= w_base + addr_bw'(w_rows);
        end
      end else if (i_load) begin
        r_t    <= '0;
        r_r    <= '0;
        r_base <= '0;
      end
    end
  end

endmodule

// File: rtl/sfp_ctrl.sv
// Sequencer for sfp: one psum read per cycle, sfp accumulates each row, ReLU row written to output SRAM.
// Read in c -> acc_en c+sram_lat -> write_en +1 -> output SRAM write +1; no backpressure, no row bubbles.
module sfp_ctrl
  import sfp_pkg::*;
#(
  parameter int addr_bw  = ADDR_BW_DEF,
  parameter int cnt_bw   = CNT_BW_DEF,
  parameter int sram_lat = SRAM_LAT
) (
  input  logic        clk,
  input  logic        reset,
  sfp_ctrl_if.master  bus
);

  typedef struct packed {
    logic               vld;
    logic               last_tile;
    logic [addr_bw-1:0] row;
  } pipe_t;

  sfp_state_e r_state;
  sfp_state_e w_state_nxt;

  logic               w_load;
  logic               w_issue;
  logic               w_last_read;
  logic               w_last_tile;
  logic               w_dly_any;
  logic               w_drain_done;
  logic [addr_bw-1:0] w_addr;
  logic [addr_bw-1:0] w_row;
  pipe_t              w_acc;

  pipe_t                  r_rd;
  pipe_t [sram_lat-1:0]   r_dly;
  logic                   r_wr_vld;
  logic [addr_bw-1:0]     r_wr_row;
  logic                   r_out_vld;
  logic [addr_bw-1:0]     r_out_a;
  logic [addr_bw-1:0]     r_psum_a;
  logic                   r_busy;
  logic                   r_done;

  sfp_addr_gen #(
    .addr_bw (addr_bw),
    .cnt_bw  (cnt_bw)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_step      (w_issue),
    .i_tiles     (bus.cfg_tiles),
    .i_rows      (bus.cfg_rows),
    .o_addr      (w_addr),
    .o_row       (w_row),
    .o_last_tile (w_last_tile),
    .o_last_read (w_last_read)
  );

  assign w_acc = r_dly[sram_lat-1];

  always_comb begin
    w_dly_any = 1'b0;
    for (int i = 0; i < sram_lat; i++) begin
      w_dly_any = w_dly_any | r_dly[i].vld;
    end
  end

  // Once reads stop, a write_en with nothing behind it is the final row; its SRAM write lands during FIN.
  assign w_drain_done = r_wr_vld && !r_rd.vld && !w_dly_any;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if ((bus.cfg_tiles != '0) && (bus.cfg_rows != '0)) begin
            w_load      = 1'b1;
            w_issue     = 1'b1;
            w_state_nxt = w_last_read ? DRAIN : RUN;
          end else begin
            w_state_nxt = FIN;
          end
        end
      end
      RUN: begin
        w_issue = 1'b1;
        if (w_last_read) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_drain_done) begin
          w_state_nxt = FIN;
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd      <= '0;
      r_dly     <= '0;
      r_wr_vld  <= 1'b0;
      r_wr_row  <= '0;
      r_out_vld <= 1'b0;
      r_out_a   <= '0;
      r_psum_a  <= '0;
    end else begin
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (r_state == FIN);

      r_rd.vld       <= w_issue;
      r_rd.last_tile <= w_last_tile;
      r_rd.row       <= w_row;
      if (w_issue) begin
        r_psum_a <= w_addr;
      end

      // Row tag rides alongside the SRAM read latency so write/out stages know which row retires.
      r_dly[0] <= r_rd;
      for (int i = 1; i < sram_lat; i++) begin
        r_dly[i] <= r_dly[i-1];
      end

      r_wr_vld  <= w_acc.vld && w_acc.last_tile;
      r_wr_row  <= w_acc.row;
      r_out_vld <= r_wr_vld;
      if (r_wr_vld) begin
        r_out_a <= r_wr_row;
      end
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.psum_cen     = r_rd.vld ? CEN_ON : CEN_OFF;
  assign bus.psum_wen     = WEN_OFF;
  assign bus.psum_a       = r_psum_a;
  assign bus.sfp_acc_en   = w_acc.vld;
  assign bus.sfp_write_en = r_wr_vld;
  assign bus.out_cen      = r_out_vld ? CEN_ON : CEN_OFF;
  assign bus.out_wen      = r_out_vld ? WEN_ON : WEN_OFF;
  assign bus.out_a        = r_out_a;

endmodule

// File: tb/tb_sfp_ctrl.sv
// Bench for sfp_ctrl: behavioural psum SRAM and sfp around the DUT, expected rows from plain sums.
`timescale 1ns/1ps
module tb_sfp_ctrl;

  localparam int CW = 11;
  localparam int AW = 11;
  localparam logic [29:0] RST_EXP = {1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 11'd0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sfp_ctrl_if #(.addr_bw(AW), .cnt_bw(CW)) bus ();
  sfp_ctrl #(.addr_bw(AW), .cnt_bw(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  sfp_ctrl_if #(.addr_bw(4), .cnt_bw(4)) wbus ();
  sfp_ctrl #(.addr_bw(4), .cnt_bw(4)) dut_w (.clk(clk), .reset(reset), .bus(wbus));

  int psum_mem [0:2047];
  int psum_q = 0;
  int sfp_acc = 0;
  int sfp_out = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Environment: psum SRAM (1-cycle read) and sfp (clear-then-accumulate, registered ReLU out).
  always @(posedge clk) begin
    if (!bus.psum_cen) psum_q <= psum_mem[bus.psum_a];
    if (reset) begin
      sfp_acc <= 0;
      sfp_out <= 0;
    end else begin
      if (bus.sfp_write_en) sfp_out <= (sfp_acc > 0) ? sfp_acc : 0;
      if (bus.sfp_acc_en) sfp_acc <= (bus.sfp_write_en ? 0 : sfp_acc) + psum_q;
      else if (bus.sfp_write_en) sfp_acc <= 0;
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  int rd_cyc[$], rd_adr[$], wr_cyc[$], wr_adr[$], wr_dat[$], dn_cyc[$];
  int busy_cnt, busy_first, ovl_cnt, wen_bad;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic logic [29:0] rst_view();
    return {bus.busy, bus.done, bus.psum_cen, bus.psum_wen, bus.psum_a,
            bus.sfp_acc_en, bus.sfp_write_en, bus.out_cen, bus.out_wen, bus.out_a};
  endfunction

  task automatic clear_mon();
    rd_cyc.delete(); rd_adr.delete();
    wr_cyc.delete(); wr_adr.delete(); wr_dat.delete();
    dn_cyc.delete();
    busy_cnt = 0; busy_first = -1; ovl_cnt = 0; wen_bad = 0;
  endtask

  task automatic sample(input int k);
    if (!bus.psum_cen) begin
      rd_cyc.push_back(k);
      rd_adr.push_back(int'(bus.psum_a));
    end
    if (!bus.out_cen) begin
      wr_cyc.push_back(k);
      wr_adr.push_back(int'(bus.out_a));
      wr_dat.push_back(sfp_out);
      if (bus.out_wen) wen_bad++;
    end
    if (!bus.psum_wen) wen_bad++;
    if (bus.done) dn_cyc.push_back(k);
    if (bus.busy) begin
      busy_cnt++;
      if (busy_first < 0) busy_first = k;
    end
    if (bus.sfp_acc_en && bus.sfp_write_en) ovl_cnt++;
  endtask

  task automatic fill(input int T, input int R, input int mode);
    for (int t = 0; t < T; t++)
      for (int r = 0; r < R; r++)
        psum_mem[t*R + r] = (mode == 1) ? 10*t + r + 1 : int'($urandom_range(0, 200)) - 100;
  endtask

  task automatic run_pass(input int T, input int R, input int abort_at, input bit inject);
    int nz, exp_done, errs, derrs, inj_k, lim, last_k, sum, idx, expv;
    clear_mon();
    nz = (T != 0 && R != 0) ? 1 : 0;
    exp_done = (nz != 0) ? T*R + 4 : 2;
    inj_k = inject ? int'($urandom_range(2, T*R + 2)) : -1;
    lim = T*R + 24;
    last_k = lim;
    @(posedge clk); #1;
    for (int k = 0; k <= last_k; k++) begin
      bus.start     = (k == 0) || (k == inj_k);
      bus.cfg_tiles = (k == 0) ? CW'(T) : CW'($urandom_range(0, 15));
      bus.cfg_rows  = (k == 0) ? CW'(R) : CW'($urandom_range(0, 15));
      reset         = (abort_at >= 0) && (k == abort_at);
      @(negedge clk);
      if (abort_at >= 0 && k == abort_at + 1) begin
        chk("abort_outs", rst_view(), RST_EXP);
        clear_mon();
        last_k = k + 6;
      end
      sample(k);
      if (abort_at < 0 && dn_cyc.size() != 0 && last_k == lim) last_k = k + 3;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    reset = 1'b0;
    if (abort_at >= 0) begin
      chk("abort_rd", rd_cyc.size(), 0);
      chk("abort_wr", wr_cyc.size(), 0);
      chk("abort_busy", busy_cnt, 0);
      chk("abort_done", dn_cyc.size(), 0);
      return;
    end
    chk("done_cnt", dn_cyc.size(), 1);
    chk("done_cyc", (dn_cyc.size() != 0) ? dn_cyc[0] : -1, exp_done);
    chk("rd_cnt", rd_cyc.size(), T*R);
    errs = 0;
    for (int r = 0; r < R && nz != 0; r++)
      for (int t = 0; t < T; t++) begin
        idx = r*T + t;
        if (idx >= rd_cyc.size() || rd_adr[idx] != t*R + r || rd_cyc[idx] != idx + 1) errs++;
      end
    chk("rd_seq", errs, 0);
    chk("wr_cnt", wr_cyc.size(), (nz != 0) ? R : 0);
    errs = 0;
    derrs = 0;
    for (int r = 0; r < R && nz != 0; r++) begin
      sum = 0;
      for (int t = 0; t < T; t++) sum += psum_mem[t*R + r];
      expv = (sum > 0) ? sum : 0;
      if (r >= wr_cyc.size()) begin
        errs++;
      end else begin
        if (wr_adr[r] != r || wr_cyc[r] != (r+1)*T + 3) errs++;
        if (wr_dat[r] != expv) derrs++;
      end
    end
    chk("wr_seq", errs, 0);
    chk("wr_dat", derrs, 0);
    chk("busy_cnt", busy_cnt, exp_done - 1);
    chk("busy_first", busy_first, 1);
    chk("acc_wr_overlap", ovl_cnt, (nz != 0) ? R - 1 : 0);
    chk("wen", wen_bad, 0);
  endtask

  task automatic run_wrap();
    int seq[$];
    int errs, mask, dn;
    errs = 0; mask = 0; dn = -1;
    @(posedge clk); #1;
    wbus.start = 1'b1;
    wbus.cfg_tiles = 4'd4;
    wbus.cfg_rows = 4'd4;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!wbus.psum_cen) seq.push_back(int'(wbus.psum_a));
      if (wbus.done && dn < 0) dn = k;
      @(posedge clk); #1;
      wbus.start = 1'b0;
    end
    chk("wrap_cnt", seq.size(), 16);
    for (int i = 0; i < seq.size(); i++) begin
      if (seq[i] != (i % 4) * 4 + i / 4) errs++;
      mask |= 1 << seq[i];
    end
    chk("wrap_seq", errs, 0);
    chk("wrap_cover", mask, 32'hFFFF);
    chk("wrap_done", dn, 20);
  endtask

  initial begin
    int T, R;
    bus.start = 1'b0; bus.cfg_tiles = '0; bus.cfg_rows = '0;
    wbus.start = 1'b0; wbus.cfg_tiles = '0; wbus.cfg_rows = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", rst_view(), RST_EXP);
    @(posedge clk); #1;
    reset = 1'b0;

    fill(3, 4, 1);
    run_pass(3, 4, -1, 1'b1);

    psum_mem[0] = -5; psum_mem[1] = -7; psum_mem[2] = 3;
    run_pass(3, 1, -1, 1'b0);

    fill(1, 8, 0);
    run_pass(1, 8, -1, 1'b0);

    run_pass(3, 0, -1, 1'b0);
    run_pass(0, 5, -1, 1'b0);

    fill(9, 36, 0);
    run_pass(9, 36, 50, 1'b0);
    fill(9, 36, 0);
    run_pass(9, 36, -1, 1'b0);

    run_wrap();

    for (int i = 0; i < 10; i++) begin
      T = int'($urandom_range(1, 6));
      R = int'($urandom_range(1, 8));
      fill(T, R, 0);
      run_pass(T, R, -1, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
